// File: rtl/param_sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// param_sync_fifo_pkg
// Shared defaults and helpers for the parameterised synchronous FIFO.
//   DEF_*        default parameter values used by param_sync_fifo and its
//                storage sub-module
//   ptr_width()  pointer width for a given depth: one address bit per
//                power of two plus a wrap bit that tells full from empty
// -----------------------------------------------------------------------------
package param_sync_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_DEPTH      = 16;
   localparam int DEF_AF_MARGIN  = 2;
   localparam int DEF_AE_MARGIN  = 2;

   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/param_sync_fifo_mem.sv
// -----------------------------------------------------------------------------
// param_sync_fifo_mem
// DEPTH x DATA_WIDTH register array for the synchronous FIFO. The array and
// the read register carry no reset; the top masks the read register until
// the first read after reset.
// Ports:
//   clk      system clock, rising edge
//   wr_en    store wr_data at wr_addr
//   wr_addr  write address
//   wr_data  write word
//   rd_en    load rd_word from rd_addr
//   rd_addr  read address
//   rd_word  registered read word, holds when rd_en is low
// -----------------------------------------------------------------------------
module param_sync_fifo_mem
   import param_sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int ADDR_W     = ptr_width(DEF_DEPTH) - 1
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_word
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_word <= mem_q[rd_addr];
      end
   end

endmodule

// File: rtl/param_sync_fifo.sv
// -----------------------------------------------------------------------------
// param_sync_fifo
// Single-clock FIFO with fill count, almost-full/almost-empty flags and
// optional sticky overflow/underflow flags.
// Build option: define PARAM_SYNC_FIFO_ERR_EN to include the sticky error
// flags; without it overflow/underflow read 0 and errClr is ignored.
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   wData/winc    write word / write request (ignored while wFull)
//   wFull         DEPTH words held
//   wAlmostFull   count >= DEPTH-AF_MARGIN
//   rinc          read request (ignored while rEmpty)
//   rData         registered read word, one edge after an accepted read
//   rEmpty        no words held
//   rAlmostEmpty  count <= AE_MARGIN
//   count         fill level 0..DEPTH
//   errClr        clears overflow/underflow
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
// -----------------------------------------------------------------------------
module param_sync_fifo
   import param_sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AF_MARGIN  = DEF_AF_MARGIN,
   parameter int AE_MARGIN  = DEF_AE_MARGIN
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [DATA_WIDTH-1:0]        wData,
   input  logic                         winc,
   output logic                         wFull,
   output logic                         wAlmostFull,
   input  logic                         rinc,
   output logic [DATA_WIDTH-1:0]        rData,
   output logic                         rEmpty,
   output logic                         rAlmostEmpty,
   output logic [ptr_width(DEPTH)-1:0]  count,
   input  logic                         errClr,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int PTR_W  = ptr_width(DEPTH);
   localparam int ADDR_W = PTR_W - 1;

   localparam int unsigned AF_LEVEL_I = DEPTH - AF_MARGIN;
   localparam int unsigned AE_LEVEL_I = AE_MARGIN;
   localparam logic [PTR_W-1:0] AF_LEVEL = AF_LEVEL_I[PTR_W-1:0];
   localparam logic [PTR_W-1:0] AE_LEVEL = AE_LEVEL_I[PTR_W-1:0];
   localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};

   logic [PTR_W-1:0]      wptr;
   logic [PTR_W-1:0]      rptr;
   logic                  wr_ok;
   logic                  rd_ok;
   logic                  rd_valid;
   logic [DATA_WIDTH-1:0] rd_word;

   // Extra wrap bit: equal pointers mean empty, MSB-only difference means full.
   assign rEmpty       = (wptr == rptr);
   assign wFull        = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                         (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
   assign count        = wptr - rptr;
   assign wAlmostFull  = (count >= AF_LEVEL);
   assign rAlmostEmpty = (count <= AE_LEVEL);

   // Acceptance uses flags from the previous edge, so a full FIFO with both
   // requests only reads and an empty FIFO with both requests only writes.
   assign wr_ok = winc && !wFull;
   assign rd_ok = rinc && !rEmpty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr_ok) begin
            wptr <= wptr + PTR_ONE;
         end
         if (rd_ok) begin
            rptr <= rptr + PTR_ONE;
         end
      end
   end

   param_sync_fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (ADDR_W)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_ok),
      .wr_addr (wptr[ADDR_W-1:0]),
      .wr_data (wData),
      .rd_en   (rd_ok),
      .rd_addr (rptr[ADDR_W-1:0]),
      .rd_word (rd_word)
   );

   // The read register has no reset; hide stale contents until the first
   // read after reset has reloaded it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_valid <= 1'b0;
      end else if (rd_ok) begin
         rd_valid <= 1'b1;
      end
   end

   assign rData = rd_valid ? rd_word : '0;

`ifdef PARAM_SYNC_FIFO_ERR_EN
   // Set has priority over clear so an error in the clearing cycle is kept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (winc && wFull) begin
            overflow <= 1'b1;
         end else if (errClr) begin
            overflow <= 1'b0;
         end
         if (rinc && rEmpty) begin
            underflow <= 1'b1;
         end else if (errClr) begin
            underflow <= 1'b0;
         end
      end
   end
`else
   logic unused_err_clr;
   assign unused_err_clr = errClr;
   assign overflow       = 1'b0;
   assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
module tb_param_sync_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
`ifdef PARAM_SYNC_FIFO_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic [DW-1:0] wData;
   logic          winc;
   logic          wFull;
   logic          wAlmostFull;
   logic          rinc;
   logic [DW-1:0] rData;
   logic          rEmpty;
   logic          rAlmostEmpty;
   logic [4:0]    count;
   logic          errClr;
   logic          overflow;
   logic          underflow;

   param_sync_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AF_MARGIN  (2),
      .AE_MARGIN  (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .wData        (wData),
      .winc         (winc),
      .wFull        (wFull),
      .wAlmostFull  (wAlmostFull),
      .rinc         (rinc),
      .rData        (rData),
      .rEmpty       (rEmpty),
      .rAlmostEmpty (rAlmostEmpty),
      .count        (count),
      .errClr       (errClr),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Scoreboard: words pushed when a write is accepted, popped into
   // exp_rdata when a read is accepted.
   logic [DW-1:0] sb [$];
   logic [DW-1:0] exp_rdata = '0;
   bit            m_ovf     = 1'b0;
   bit            m_udf     = 1'b0;

   // One clock with the given requests; inputs change 1 ns after the edge
   // and outputs are sampled there too.
   task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input logic clr);
      int sz;
      bit acc_w;
      bit acc_r;
      sz     = sb.size();
      acc_w  = w && (sz < DEPTH);
      acc_r  = r && (sz > 0);
      winc   = w;
      wData  = d;
      rinc   = r;
      errClr = clr;
      if (ERR_EN) begin
         if (w && sz == DEPTH) m_ovf = 1'b1;
         else if (clr)         m_ovf = 1'b0;
         if (r && sz == 0)     m_udf = 1'b1;
         else if (clr)         m_udf = 1'b0;
      end
      @(posedge clk);
      #1;
      if (acc_r) exp_rdata = sb.pop_front();
      if (acc_w) sb.push_back(d);
      winc   = 1'b0;
      rinc   = 1'b0;
      errClr = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; winc = 1'b0; rinc = 1'b0; errClr = 1'b0; wData = '0;
      #3;
      n_total++; if (count !== 5'd0) $display("FAIL reset_count got %0d want 0", count); else n_pass++;
      n_total++; if (rEmpty !== 1'b1 || rAlmostEmpty !== 1'b1) $display("FAIL reset_empty got %b%b want 11", rEmpty, rAlmostEmpty); else n_pass++;
      n_total++; if (wFull !== 1'b0 || wAlmostFull !== 1'b0) $display("FAIL reset_full got %b%b want 00", wFull, wAlmostFull); else n_pass++;
      n_total++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL reset_err got %b%b want 00", overflow, underflow); else n_pass++;
      n_total++; if (rData !== 8'h00) $display("FAIL reset_rdata got %h want 00", rData); else n_pass++;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
   endtask

   task automatic test_fill();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b1, DW'(i), 1'b0, 1'b0);
         n_total++; if (count !== 5'(i + 1)) $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); else n_pass++;
         n_total++; if (wAlmostFull !== (i + 1 >= 14)) $display("FAIL fill_af[%0d] got %b want %b", i, wAlmostFull, (i + 1 >= 14)); else n_pass++;
         n_total++; if (wFull !== (i + 1 == 16)) $display("FAIL fill_full[%0d] got %b want %b", i, wFull, (i + 1 == 16)); else n_pass++;
         n_total++; if (rAlmostEmpty !== (i + 1 <= 2) || rEmpty !== 1'b0) $display("FAIL fill_ae[%0d] got %b%b", i, rAlmostEmpty, rEmpty); else n_pass++;
      end
      cycle(1'b1, 8'hAA, 1'b0, 1'b0);
      n_total++; if (count !== 5'd16 || wFull !== 1'b1) $display("FAIL fill_drop got count %0d full %b want 16 1", count, wFull); else n_pass++;
      n_total++; if (overflow !== m_ovf) $display("FAIL fill_overflow got %b want %b", overflow, m_ovf); else n_pass++;
   endtask

   task automatic test_drain();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0);
         n_total++; if (rData !== exp_rdata || exp_rdata !== DW'(i)) $display("FAIL drain_data[%0d] got %h want %h", i, rData, DW'(i)); else n_pass++;
         n_total++; if (count !== 5'(DEPTH - 1 - i)) $display("FAIL drain_count[%0d] got %0d want %0d", i, count, DEPTH - 1 - i); else n_pass++;
      end
      n_total++; if (rEmpty !== 1'b1) $display("FAIL drain_empty got %b want 1", rEmpty); else n_pass++;
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_total++; if (underflow !== m_udf) $display("FAIL drain_underflow got %b want %b", underflow, m_udf); else n_pass++;
      n_total++; if (rData !== 8'h0F) $display("FAIL drain_hold got %h want 0f", rData); else n_pass++;
      cycle(1'b0, '0, 1'b0, 1'b1);
      n_total++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL errclr got %b%b want 00", overflow, underflow); else n_pass++;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 8; i++) cycle(1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
      n_total++; if (count !== 5'd8) $display("FAIL b2b_prefill got %0d want 8", count); else n_pass++;
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, DW'(8'h40 + i), 1'b1, 1'b0);
         n_total++; if (count !== 5'd8) $display("FAIL b2b_count[%0d] got %0d want 8", i, count); else n_pass++;
         n_total++; if (rData !== exp_rdata) $display("FAIL b2b_data[%0d] got %h want %h", i, rData, exp_rdata); else n_pass++;
      end
   endtask

   task automatic test_full_empty_both();
      for (int g = 0; g < 40 && sb.size() > 0; g++) begin
         cycle(1'b0, '0, 1'b1, 1'b0);
         n_total++; if (rData !== exp_rdata) $display("FAIL flush_data got %h want %h", rData, exp_rdata); else n_pass++;
      end
      n_total++; if (rEmpty !== 1'b1) $display("FAIL flush_empty got %b want 1", rEmpty); else n_pass++;
      cycle(1'b1, 8'h3C, 1'b1, 1'b0);
      n_total++; if (count !== 5'd1) $display("FAIL empty_both_count got %0d want 1", count); else n_pass++;
      n_total++; if (underflow !== m_udf) $display("FAIL empty_both_underflow got %b want %b", underflow, m_udf); else n_pass++;
      n_total++; if (rData !== exp_rdata) $display("FAIL empty_both_hold got %h want %h", rData, exp_rdata); else n_pass++;
      for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, DW'(8'h80 + i), 1'b0, 1'b0);
      n_total++; if (wFull !== 1'b1) $display("FAIL full_both_pre got %b want 1", wFull); else n_pass++;
      cycle(1'b1, 8'h77, 1'b1, 1'b0);
      n_total++; if (count !== 5'd15) $display("FAIL full_both_count got %0d want 15", count); else n_pass++;
      n_total++; if (overflow !== m_ovf) $display("FAIL full_both_overflow got %b want %b", overflow, m_ovf); else n_pass++;
      n_total++; if (rData !== 8'h3C) $display("FAIL full_both_data got %h want 3c", rData); else n_pass++;
      for (int i = 0; i < DEPTH - 1; i++) begin
         cycle(1'b0, '0, 1'b1, 1'b0);
         n_total++; if (rData !== exp_rdata) $display("FAIL full_both_drain[%0d] got %h want %h", i, rData, exp_rdata); else n_pass++;
      end
      n_total++; if (rEmpty !== 1'b1) $display("FAIL full_both_empty got %b want 1", rEmpty); else n_pass++;
      cycle(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 40; i++) begin
         cycle(1'b1, DW'(i * 7 + 3), 1'b0, 1'b0);
         cycle(1'b0, '0, 1'b1, 1'b0);
         n_total++; if (rData !== exp_rdata) $display("FAIL wrap_data[%0d] got %h want %h", i, rData, exp_rdata); else n_pass++;
      end
      n_total++; if (overflow !== 1'b0 || underflow !== 1'b0 || rEmpty !== 1'b1) $display("FAIL wrap_flags got %b%b%b want 001", overflow, underflow, rEmpty); else n_pass++;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 10; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b0, 1'b0);
      n_total++; if (count !== 5'd10) $display("FAIL rstmid_pre got %0d want 10", count); else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_total++; if (count !== 5'd0 || rEmpty !== 1'b1) $display("FAIL rstmid_count got %0d empty %b want 0 1", count, rEmpty); else n_pass++;
      n_total++; if (rData !== 8'h00) $display("FAIL rstmid_rdata got %h want 00", rData); else n_pass++;
      #2 rst = 1'b1;
      sb.delete();
      exp_rdata = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
      cycle(1'b1, 8'h5C, 1'b0, 1'b0);
      n_total++; if (count !== 5'd1) $display("FAIL rstmid_write got %0d want 1", count); else n_pass++;
      cycle(1'b0, '0, 1'b1, 1'b0);
      n_total++; if (rData !== 8'h5C || rEmpty !== 1'b1) $display("FAIL rstmid_read got %h empty %b want 5c 1", rData, rEmpty); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_back_to_back();
      test_full_empty_both();
      test_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >=4.
REQ-003 Parameter AF_MARGIN, default 2, almost-full threshold distance from DEPTH (0..DEPTH-1).
REQ-004 Parameter AE_MARGIN, default 2, almost-empty threshold (0..DEPTH-1).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 wData  input  DATA_WIDTH  write data.
REQ-008 winc  input  1  write request.
REQ-009 wFull  output  1  FIFO holds DEPTH words.
REQ-010 wAlmostFull  output  1  count >= DEPTH-AF_MARGIN.
REQ-011 rinc  input  1  read request.
REQ-012 rData  output  DATA_WIDTH  registered read data.
REQ-013 rEmpty  output  1  FIFO holds zero words.
REQ-014 rAlmostEmpty  output  1  count <= AE_MARGIN.
REQ-015 count  output  clog2(DEPTH)+1  current fill level, 0..DEPTH.
REQ-016 errClr  input  1  clears sticky error flags.
REQ-017 overflow  output  1  sticky: write attempted while full.
REQ-018 underflow  output  1  sticky: read attempted while empty.

Function
REQ-019 Write accepted iff winc=1 and wFull=1 is false at the edge; wData is stored at the write pointer, which then increments.
REQ-020 Read accepted iff rinc=1 and rEmpty=0; rData loads the entry at the read pointer on that edge (1-cycle latency), the read pointer increments; otherwise rData holds.
REQ-021 Pointers are clog2(DEPTH)+1 bits and wrap naturally; empty when pointers are equal, full when MSBs differ and remaining bits are equal.
REQ-022 count = wptr - rptr modulo 2^(clog2(DEPTH)+1); all flags derive from registered pointers and reflect state after the last edge.
REQ-023 Simultaneous winc and rinc with 0<count<DEPTH: both accepted, count unchanged.
REQ-024 When full, winc with rinc: read accepted, write rejected (count becomes DEPTH-1); when empty, winc with rinc: write accepted, read rejected.
REQ-025 Rejected operations never modify memory, pointers or rData.
REQ-026 overflow sets on an edge with winc=1 and wFull=1; underflow sets on rinc=1 and rEmpty=1; both clear on errClr=1; set wins over clear in the same cycle.

Reset
REQ-027 rst=0 immediately forces pointers=0, count=0, rData=0, rEmpty=1, rAlmostEmpty=1, wFull=0, wAlmostFull=0, overflow=0, underflow=0, regardless of clk.
REQ-028 Reset mid-operation discards all stored words; memory array contents are not reset and are never visible before being rewritten.
REQ-029 First write may be accepted on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro PARAM_SYNC_FIFO_ERR_EN defined: overflow/underflow/errClr logic per REQ-026.
REQ-031 PARAM_SYNC_FIFO_ERR_EN undefined: ports remain, overflow and underflow tied 0, errClr ignored, no error registers synthesised.

Structure
REQ-032 Package param_sync_fifo_pkg holds default parameter constants and the pointer-width computation function.
REQ-033 Storage is sub-module param_sync_fifo_mem: DEPTH x DATA_WIDTH register array, one synchronous write port, one synchronous registered read port, no reset.

Verification (DATA_WIDTH=8, DEPTH=16, margins=2, ERR_EN defined)
REQ-034 Write 0x00..0x0F on consecutive cycles -> count 1..16, wAlmostFull from count 14, wFull=1 after 16th; 17th write 0xAA dropped, overflow=1.
REQ-035 Then read 16 times -> rData 0x00..0x0F in order one edge after each accepted rinc; rEmpty=1 after last; extra rinc -> underflow=1, rData holds 0x0F; errClr pulse -> both flags 0.
REQ-036 Fill to 8, then winc=rinc=1 for 20 cycles with incrementing data -> count stays 8, output order matches input order.
REQ-037 Full FIFO, winc=rinc=1 one cycle -> read accepted, count=15, overflow=1, stored data unchanged.
REQ-038 40 interleaved write/read pairs (pointer wrap past 16 twice) -> data in order, no error flags.
REQ-039 Fill to 10, drop rst for 3 ns between clock edges -> count=0, rEmpty=1, rData=0 immediately; next write/read returns the new word.
